// File: rtl/colour_sequencer.sv
// colour_sequencer: walks the RGB converter through colour indices 0..7.
// For each colour it enables the converter for the read latency, captures the
// returned word and presents it downstream with a one-cycle valid strobe.
// It then dwells for a fixed time (auto mode) or waits for a step pulse (step mode).
module colour_sequencer #(
  parameter int unsigned DWELL      = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic        step,
  output logic [2:0]  colour,
  output logic        ena,
  input  logic [23:0] rgb_in,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  output logic        busy
);

  localparam int unsigned LatW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned DwW  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [LatW-1:0] LatLast = LatW'(RD_LATENCY - 1);
  localparam logic [DwW-1:0]  DwLast  = DwW'(DWELL - 1);
  localparam logic [LatW-1:0] LatOne  = LatW'(1);
  localparam logic [DwW-1:0]  DwOne   = DwW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapture,
    StHold
  } state_e;

  state_e          state_q;
  logic [LatW-1:0] lat_cnt_q;
  logic [DwW-1:0]  dwell_cnt_q;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      colour      <= 3'd0;
      ena         <= 1'b0;
      rgb_out     <= 24'd0;
      rgb_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Strobe is only ever set by the CAPTURE branch below.
      rgb_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StFetch;
            lat_cnt_q <= '0;
            ena       <= 1'b1;
            busy      <= 1'b1;
          end
        end

        StFetch: begin
          if (lat_cnt_q == LatLast) begin
            state_q   <= StCapture;
            lat_cnt_q <= '0;
            ena       <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q + LatOne;
          end
        end

        StCapture: begin
          rgb_out   <= rgb_in;
          rgb_valid <= 1'b1;
          state_q   <= StHold;
        end

        StHold: begin
          if (stop) begin
            // Colour and rgb_out are kept; a later start re-fetches this colour
            // with a fresh dwell.
            state_q     <= StIdle;
            busy        <= 1'b0;
            dwell_cnt_q <= '0;
          end else if (mode) begin
            if (dwell_cnt_q == DwLast) begin
              dwell_cnt_q <= '0;
              colour      <= colour + 3'd1;
              state_q     <= StFetch;
              lat_cnt_q   <= '0;
              ena         <= 1'b1;
            end else begin
              dwell_cnt_q <= dwell_cnt_q + DwOne;
            end
          end else begin
            dwell_cnt_q <= '0;
            if (step) begin
              colour    <= colour + 3'd1;
              state_q   <= StFetch;
              lat_cnt_q <= '0;
              ena       <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          ena     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
